display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//  Multiplexed 6-digit 7-segment scanner downstream of the clock counters.
//  Consumes packed-BCD Hour/Minute/Second and drives one shared segment bus plus six digit enables.
//  Also blinks the field being adjusted, blanks a leading hour zero, and flashes the separators.
// PARAMETERS
//  SCAN_DIV       2    CP cycles per digit slot; must be >= 2 (cycle 0 of each slot is dead time)
//  BLINK_DIV      500  CP cycles per blink half-period (CP = 1 kHz gives 1 Hz blink)
//  SEG_ACTIVE_LOW 0    1: Seg/Dp inverted at the output register
//  DIG_ACTIVE_LOW 0    1: DigSel inverted at the output register
// PORTS
//  CP        in   1  scan clock, rising edge
//  CR        in   1  asynchronous reset, active-high
//  Hour      in   8  BCD hours, [7:4] tens, [3:0] ones
//  Minute    in   8  BCD minutes
//  Second    in   8  BCD seconds
//  AdjMinKey in   1  1 = minute field is being adjusted (blink it)
//  AdjHrKey  in   1  1 = hour field is being adjusted (blink it)
//  Seg       out  7  segments {g,f,e,d,c,b,a}, Seg[0]=a
//  Dp        out  1  decimal point / separator
//  DigSel    out  6  one-hot digit enable; [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens, [4]=hr ones, [5]=hr tens
// BEHAVIOUR
//  Reset (CR=1, asynchronous, takes effect mid-operation too):
//   - pre=0, idx=0, blink counter=0, phase=0, snapshot=24'h0, first-load flag set.
//   - Seg, Dp, DigSel all at their inactive level.
//  Prescaler pre counts 0..SCAN_DIV-1 and wraps. On the edge where pre==SCAN_DIV-1, idx advances 0..5 and wraps 5->0.
//  Snapshot {Hour,Minute,Second} is loaded on two edges only:
//   - the first CP edge after CR deasserts;
//   - every edge where idx wraps 5->0.
//   All six digits of one frame therefore come from one snapshot (no tearing).
//  Outputs are registered and reflect the pre/idx/phase/snapshot values produced on the same edge:
//   - DigSel = all off when pre==0 (dead time), else onehot(idx).
//   - Seg = pattern of the snapshot nibble selected by idx, unless that digit is blanked.
//  Patterns (active-high, hex):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; nibble >9 -> 40 (dash).
//  Blanking (Seg all off), any condition sufficient:
//   - idx==5 and hour tens==0 (leading-zero suppression);
//   - idx in {2,3}, AdjMinKey=1 and phase=1;
//   - idx in {4,5}, AdjHrKey=1 and phase=1.
//   Both keys may be high together; both fields then blink in phase.
//  Blink counter counts 0..BLINK_DIV-1; phase toggles on its wrap edge. Keys are sampled live, not snapshotted.
//  Dp = on when idx in {2,4} and phase=0; otherwise off (colon-style flash).
//  Polarity inversion is applied last. Reset levels are the inverted-off levels when the ACTIVE_LOW parameters are 1.
//  Latency: an input change is displayed no later than 2 frames (2*6*SCAN_DIV cycles) after it occurs.
// TESTING (SCAN_DIV=2, BLINK_DIV=4, active-high polarity)
//  1. Reset:
//     - CR=1 mid-scan -> Seg=0, Dp=0, DigSel=0 immediately.
//     - Release with H/M/S=12/34/56 -> edge1 DigSel=0; edge2 DigSel=000001, Seg=7D ('6').
//  2. Frame order:
//     - H/M/S=12/34/56, keys 0 -> slots in order show Seg 7D,6D,66,4F,5B,06 on DigSel bit 0..5.
//     - Each slot is preceded by one dead cycle with DigSel=0.
//  3. Snapshot:
//     - Change Second 56->57 while idx=2 -> rest of frame unchanged.
//     - Next frame digit 0 shows 07.
//  4. Leading zero / invalid:
//     - Hour=09 -> digit 5 Seg=00, digit 4 Seg=6F.
//     - Second=8'h5A -> digit 0 Seg=40.
//  5. Blink:
//     - AdjMinKey=1 -> digits 2,3 Seg=00 whenever phase=1, normal when phase=0; phase toggles every 4 cycles.
//     - Dp=1 only on digits 2,4 with phase=0.
//  6. Polarity: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> reset gives Seg=7F, Dp=1, DigSel=3F; test 2 values bit-inverted.

Source files
------------

// File: rtl/display_scan_driver.sv
// Multiplexed 6-digit 7-segment scanner: snapshots BCD H/M/S once per frame,
// scans digits with a dead cycle per slot, blinks adjusted fields, flashes separators.
module display_scan_driver #(
    parameter int SCAN_DIV       = 2,
    parameter int BLINK_DIV      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic       AdjMinKey,
    input  logic       AdjHrKey,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [5:0] DigSel
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             phase_q, phase_d;
    logic [23:0]      snap_q, snap_d;
    logic             first_q, first_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       dig_q, dig_d;

    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_raw;
    logic [5:0]       dig_raw;
    logic             dp_raw;

    function automatic logic [6:0] seg_pattern(input logic [3:0] n);
        case (n)
            4'd0:    seg_pattern = 7'h3F;
            4'd1:    seg_pattern = 7'h06;
            4'd2:    seg_pattern = 7'h5B;
            4'd3:    seg_pattern = 7'h4F;
            4'd4:    seg_pattern = 7'h66;
            4'd5:    seg_pattern = 7'h6D;
            4'd6:    seg_pattern = 7'h7D;
            4'd7:    seg_pattern = 7'h07;
            4'd8:    seg_pattern = 7'h7F;
            4'd9:    seg_pattern = 7'h6F;
            default: seg_pattern = 7'h40;
        endcase
    endfunction

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        snap_d  = snap_q;
        first_d = 1'b0;

        // The first edge after reset only captures the snapshot; scanning starts on the next one.
        if (first_q) begin
            snap_d = {Hour, Minute, Second};
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (idx_q == 3'd5) begin
                    idx_d  = 3'd0;
                    snap_d = {Hour, Minute, Second};
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end

            if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end

        case (idx_d)
            3'd0:    nib = snap_d[3:0];
            3'd1:    nib = snap_d[7:4];
            3'd2:    nib = snap_d[11:8];
            3'd3:    nib = snap_d[15:12];
            3'd4:    nib = snap_d[19:16];
            default: nib = snap_d[23:20];
        endcase

        blank = ((idx_d == 3'd5) && (snap_d[23:20] == 4'd0))
             || (((idx_d == 3'd2) || (idx_d == 3'd3)) && AdjMinKey && phase_d)
             || (((idx_d == 3'd4) || (idx_d == 3'd5)) && AdjHrKey && phase_d);

        seg_raw = blank ? 7'h00 : seg_pattern(nib);
        dig_raw = (pre_d == '0) ? 6'b000000 : (6'b000001 << idx_d);
        dp_raw  = ((idx_d == 3'd2) || (idx_d == 3'd4)) && !phase_d;

        seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
        dp_d  = dp_raw ^ SEG_ACTIVE_LOW;
        dig_d = dig_raw ^ {6{DIG_ACTIVE_LOW}};
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            pre_q   <= '0;
            idx_q   <= 3'd0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            snap_q  <= 24'h0;
            first_q <= 1'b1;
            seg_q   <= {7{SEG_ACTIVE_LOW}};
            dp_q    <= SEG_ACTIVE_LOW;
            dig_q   <= {6{DIG_ACTIVE_LOW}};
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign Seg    = seg_q;
    assign Dp     = dp_q;
    assign DigSel = dig_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: active-high and fully inverted instances
// driven in lockstep, checked against hand-computed scan frames.
module tb_display_scan_driver;

    logic       CP;
    logic       CR;
    logic [7:0] Hour, Minute, Second;
    logic       AdjMinKey, AdjHrKey;
    logic [6:0] Seg, SegN;
    logic       Dp, DpN;
    logic [5:0] DigSel, DigSelN;

    int total = 0;
    int bad   = 0;
    int j     = -1;

    display_scan_driver #(
        .SCAN_DIV(2), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .CP(CP), .CR(CR), .Hour(Hour), .Minute(Minute), .Second(Second),
        .AdjMinKey(AdjMinKey), .AdjHrKey(AdjHrKey),
        .Seg(Seg), .Dp(Dp), .DigSel(DigSel)
    );

    display_scan_driver #(
        .SCAN_DIV(2), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_n (
        .CP(CP), .CR(CR), .Hour(Hour), .Minute(Minute), .Second(Second),
        .AdjMinKey(AdjMinKey), .AdjHrKey(AdjHrKey),
        .Seg(SegN), .Dp(DpN), .DigSel(DigSelN)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // j = number of scanning edges since the load-only edge after reset release
    task automatic run_to(input int tj);
        while (j < tj) begin
            @(posedge CP);
            #1;
            j++;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic ed, input logic [5:0] eg);
        total++;
        assert (Seg === es) else begin
            bad++; $error("FAIL %s.seg got=%h want=%h", tag, Seg, es);
        end
        total++;
        assert (Dp === ed) else begin
            bad++; $error("FAIL %s.dp got=%b want=%b", tag, Dp, ed);
        end
        total++;
        assert (DigSel === eg) else begin
            bad++; $error("FAIL %s.dig got=%b want=%b", tag, DigSel, eg);
        end
        total++;
        assert (SegN === ~es) else begin
            bad++; $error("FAIL %s.segn got=%h want=%h", tag, SegN, ~es);
        end
        total++;
        assert (DpN === ~ed) else begin
            bad++; $error("FAIL %s.dpn got=%b want=%b", tag, DpN, ~ed);
        end
        total++;
        assert (DigSelN === ~eg) else begin
            bad++; $error("FAIL %s.dign got=%b want=%b", tag, DigSelN, ~eg);
        end
    endtask

    initial begin
        CR = 1'b1;
        Hour = 8'h12; Minute = 8'h34; Second = 8'h56;
        AdjMinKey = 1'b0; AdjHrKey = 1'b0;
        #1;
        chk("por", 7'h00, 1'b0, 6'b000000);
        #11;
        CR = 1'b0;
        j = -1;
        run_to(3);
        chk("pre_rst_slot1", 7'h6D, 1'b0, 6'b000010);

        // asynchronous reset in the middle of a slot
        #2;
        CR = 1'b1;
        #1;
        chk("rst_async", 7'h00, 1'b0, 6'b000000);
        @(negedge CP);
        @(negedge CP);
        CR = 1'b0;
        j = -1;

        run_to(0);  chk("edge1_load", 7'h7D, 1'b0, 6'b000000);
        run_to(1);  chk("edge2_d0",   7'h7D, 1'b0, 6'b000001);
        run_to(2);  chk("dead_d1",    7'h6D, 1'b0, 6'b000000);
        run_to(3);  chk("f1_d1",      7'h6D, 1'b0, 6'b000010);
        run_to(5);  chk("f1_d2",      7'h66, 1'b0, 6'b000100);
        Second = 8'h57;
        Hour   = 8'h09;
        run_to(7);  chk("f1_d3",      7'h4F, 1'b0, 6'b001000);
        run_to(9);  chk("f1_d4_snap", 7'h5B, 1'b1, 6'b010000);
        run_to(11); chk("f1_d5_snap", 7'h06, 1'b0, 6'b100000);
        run_to(12); chk("f2_dead",    7'h07, 1'b0, 6'b000000);
        run_to(13); chk("f2_d0",      7'h07, 1'b0, 6'b000001);
        Second = 8'h5A;
        run_to(15); chk("f2_d1",      7'h6D, 1'b0, 6'b000010);
        run_to(17); chk("f2_d2",      7'h66, 1'b1, 6'b000100);
        run_to(21); chk("f2_d4_hr9",  7'h6F, 1'b0, 6'b010000);
        run_to(23); chk("f2_d5_lz",   7'h00, 1'b0, 6'b100000);
        AdjMinKey = 1'b1;
        run_to(25); chk("f3_d0_dash", 7'h40, 1'b0, 6'b000001);
        run_to(29); chk("f3_d2_blnk", 7'h00, 1'b0, 6'b000100);
        run_to(31); chk("f3_d3_blnk", 7'h00, 1'b0, 6'b001000);
        run_to(33); chk("f3_d4",      7'h6F, 1'b1, 6'b010000);
        run_to(35); chk("f3_d5_lz",   7'h00, 1'b0, 6'b100000);
        Hour     = 8'h12;
        AdjHrKey = 1'b1;
        run_to(37); chk("f4_d0",      7'h40, 1'b0, 6'b000001);
        run_to(41); chk("f4_d2_on",   7'h66, 1'b1, 6'b000100);
        run_to(43); chk("f4_d3_on",   7'h4F, 1'b0, 6'b001000);
        run_to(45); chk("f4_d4_blnk", 7'h00, 1'b0, 6'b010000);
        run_to(47); chk("f4_d5_blnk", 7'h00, 1'b0, 6'b100000);
        run_to(57); chk("f5_d4_on",   7'h5B, 1'b1, 6'b010000);
        run_to(59); chk("f5_d5_on",   7'h06, 1'b0, 6'b100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
